// File: rtl/data_ram_pkg.sv
// Shared widths and constants for the data RAM and its write buffer.
package data_ram_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [DATA_W-1:0] DATA_ZERO = '0;
    localparam logic EN  = 1'b1;
    localparam logic DIS = 1'b0;
endpackage

// File: rtl/data_ram_wbuf.sv
// Two-entry in-order write buffer: enqueue, drain from the head, occupancy
// count and youngest-entry address match for read bypass/hazard detection.
module data_ram_wbuf
    import data_ram_pkg::*;
#(
    parameter int IDX_W      = 10,
    parameter int WBUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq,
    input  logic [IDX_W-1:0]  enq_idx,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              deq,
    input  logic [IDX_W-1:0]  look_idx,
    output logic [1:0]        cnt,
    output logic              full,
    output logic              empty,
    output logic [IDX_W-1:0]  head_idx,
    output logic [DATA_W-1:0] head_data,
    output logic              match,
    output logic [DATA_W-1:0] match_data
);

    // Entry 0 is always the oldest; entry 1 is only valid when entry 0 is.
    logic              v0, v1;
    logic [IDX_W-1:0]  idx0, idx1;
    logic [DATA_W-1:0] data0, data1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= DIS;
            v1 <= DIS;
        end else begin
            case ({enq, deq})
                2'b11: begin
                    if (v1) begin
                        idx0  <= idx1;
                        data0 <= data1;
                        idx1  <= enq_idx;
                        data1 <= enq_data;
                    end else begin
                        idx0  <= enq_idx;
                        data0 <= enq_data;
                    end
                end
                2'b01: begin
                    idx0  <= idx1;
                    data0 <= data1;
                    v0    <= v1;
                    v1    <= DIS;
                end
                2'b10: begin
                    if (v0) begin
                        idx1  <= enq_idx;
                        data1 <= enq_data;
                        v1    <= EN;
                    end else begin
                        idx0  <= enq_idx;
                        data0 <= enq_data;
                        v0    <= EN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cnt       = {v0 & v1, v0 ^ v1};
    assign full      = (cnt == 2'(WBUF_DEPTH));
    assign empty     = ~v0;
    assign head_idx  = idx0;
    assign head_data = data0;

    // Youngest matching entry wins so duplicate addresses return the newest value.
    always_comb begin
        match      = DIS;
        match_data = DATA_ZERO;
        if (v1 && (idx1 == look_idx)) begin
            match      = EN;
            match_data = data1;
        end else if (v0 && (idx0 == look_idx)) begin
            match      = EN;
            match_data = data0;
        end
    end

endmodule

// File: rtl/data_ram.sv
// Word-addressed data RAM with a 2-entry write buffer draining on idle read-port cycles.
// DATA_RAM_FWD_EN: defined = store-to-load forwarding; undefined = stall reads that hit the buffer.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int WBUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ramwe,
    input  logic [ADDR_W-1:0] ramwaddr,
    input  logic [DATA_W-1:0] ramwdata,
    input  logic              ramre,
    input  logic [ADDR_W-1:0] ramraddr,
    output logic [DATA_W-1:0] ramdata,
    output logic              stall_req,
    output logic [1:0]        wbuf_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] widx, ridx;
    logic [DEPTH_LOG2-1:0] head_idx;
    logic [DATA_W-1:0]     head_data;
    logic [DATA_W-1:0]     match_data;
    logic                  match, full, empty;
    logic                  rd_hazard, port_free, drain, wr_stall, enq;
    logic                  unused_bits;

    assign widx = ramwaddr[DEPTH_LOG2+1:2];
    assign ridx = ramraddr[DEPTH_LOG2+1:2];

    data_ram_wbuf #(
        .IDX_W      (DEPTH_LOG2),
        .WBUF_DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .enq        (enq),
        .enq_idx    (widx),
        .enq_data   (ramwdata),
        .deq        (drain),
        .look_idx   (ridx),
        .cnt        (wbuf_cnt),
        .full       (full),
        .empty      (empty),
        .head_idx   (head_idx),
        .head_data  (head_data),
        .match      (match),
        .match_data (match_data)
    );

`ifdef DATA_RAM_FWD_EN
    assign rd_hazard   = DIS;
    assign unused_bits = ^{ramwaddr[ADDR_W-1:DEPTH_LOG2+2], ramwaddr[1:0],
                           ramraddr[ADDR_W-1:DEPTH_LOG2+2], ramraddr[1:0]};
`else
    assign rd_hazard   = ramre & match;
    assign unused_bits = ^{ramwaddr[ADDR_W-1:DEPTH_LOG2+2], ramwaddr[1:0],
                           ramraddr[ADDR_W-1:DEPTH_LOG2+2], ramraddr[1:0],
                           match_data};
`endif

    // A stalled read yields the port so the matching entry can drain and clear the hazard.
    assign port_free = ~ramre | rd_hazard;
    assign drain     = ~rst & ~empty & port_free;
    assign wr_stall  = ramwe & full & ~drain;
    assign stall_req = ~rst & (wr_stall | rd_hazard);
    assign enq       = ~rst & ramwe & ~stall_req;

    always_ff @(posedge clk) begin
        if (drain) begin
            mem[head_idx] <= head_data;
        end
    end

    always_comb begin
        ramdata = DATA_ZERO;
        if (!rst && ramre && !rd_hazard) begin
`ifdef DATA_RAM_FWD_EN
            ramdata = match ? match_data : mem[ridx];
`else
            ramdata = mem[ridx];
`endif
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: vector table plus hand-written full-buffer and reset sequences.
module tb_data_ram;

`ifdef DATA_RAM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        re;
        logic [31:0] raddr;
        logic [31:0] exp_data;
        logic        exp_stall;
        logic [1:0]  exp_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ramwe;
    logic [31:0] ramwaddr;
    logic [31:0] ramwdata;
    logic        ramre;
    logic [31:0] ramraddr;
    logic [31:0] ramdata;
    logic        stall_req;
    logic [1:0]  wbuf_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int row      = 0;

    vec_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    data_ram dut (
        .clk       (clk),
        .rst       (rst),
        .ramwe     (ramwe),
        .ramwaddr  (ramwaddr),
        .ramwdata  (ramwdata),
        .ramre     (ramre),
        .ramraddr  (ramraddr),
        .ramdata   (ramdata),
        .stall_req (stall_req),
        .wbuf_cnt  (wbuf_cnt)
    );

    function automatic vec_t mk(input logic r, input logic we, input logic [31:0] wa,
                                input logic [31:0] wd, input logic re, input logic [31:0] ra,
                                input logic [31:0] ed, input logic es, input logic [1:0] ec);
        vec_t v;
        v.rst = r;  v.we = we; v.waddr = wa; v.wdata = wd;
        v.re = re;  v.raddr = ra;
        v.exp_data = ed; v.exp_stall = es; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic check_front();
        vec_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty row %0d: no expected entry queued", row);
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (ramdata !== e.exp_data) begin
            n_fail++;
            $display("FAIL ramdata row %0d: got %h expected %h", row, ramdata, e.exp_data);
        end
        n_checks++;
        if (stall_req !== e.exp_stall) begin
            n_fail++;
            $display("FAIL stall_req row %0d: got %b expected %b", row, stall_req, e.exp_stall);
        end
        n_checks++;
        if (wbuf_cnt !== e.exp_cnt) begin
            n_fail++;
            $display("FAIL wbuf_cnt row %0d: got %0d expected %0d", row, wbuf_cnt, e.exp_cnt);
        end
    endtask

    // Drive one cycle just after the edge, check combinational/registered outputs mid-cycle.
    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        rst      = v.rst;
        ramwe    = v.we;
        ramwaddr = v.waddr;
        ramwdata = v.wdata;
        ramre    = v.re;
        ramraddr = v.raddr;
        sb.push_back(v);
        @(negedge clk);
        check_front();
        row++;
    endtask

    initial begin
        rst = 1'b1; ramwe = 1'b0; ramwaddr = '0; ramwdata = '0;
        ramre = 1'b0; ramraddr = '0;
        repeat (2) @(posedge clk);

        // rst, we, waddr, wdata, re, raddr, exp_data, exp_stall, exp_cnt
        tbl.push_back(mk(1, 1, 32'h100, 32'h77,       1, 32'h100, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,   32'h0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        0, 32'h0,   32'h0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        1, 32'h100, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        1, 32'h103, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        0, 32'h100, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h40,  32'h11,       0, 32'h0,   32'h0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        1, 32'h40,  FWD ? 32'h11 : 32'h0, !FWD, 1));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        1, 32'h40,  32'h11, 0, FWD ? 2'd1 : 2'd0));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        0, 32'h0,   32'h0, 0, FWD ? 2'd1 : 2'd0));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        0, 32'h0,   32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h8,   32'hA,        1, 32'h100, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 1, 32'h8,   32'hB,        1, 32'h100, 32'hDEADBEEF, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        1, 32'h8,   FWD ? 32'hB : 32'h0, !FWD, 2));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        1, 32'h8,   FWD ? 32'hB : 32'h0, !FWD, FWD ? 2'd2 : 2'd1));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        1, 32'h8,   32'hB, 0, FWD ? 2'd2 : 2'd0));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        0, 32'h0,   32'h0, 0, FWD ? 2'd2 : 2'd0));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        0, 32'h0,   32'h0, 0, FWD ? 2'd1 : 2'd0));
        tbl.push_back(mk(0, 0, 32'h0,   32'h0,        1, 32'h8,   32'hB, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Full buffer: write held off while reads own the port, accepted once ramre drops.
        step(mk(0, 1, 32'h10, 32'h1, 1, 32'h100, 32'hDEADBEEF, 0, 0));
        step(mk(0, 1, 32'h14, 32'h2, 1, 32'h100, 32'hDEADBEEF, 0, 1));
        step(mk(0, 1, 32'h18, 32'h3, 1, 32'h100, 32'hDEADBEEF, 1, 2));
        step(mk(0, 1, 32'h18, 32'h3, 1, 32'h100, 32'hDEADBEEF, 1, 2));
        step(mk(0, 1, 32'h18, 32'h3, 0, 32'h0,   32'h0,        0, 2));
        step(mk(0, 0, 32'h0,  32'h0, 0, 32'h0,   32'h0,        0, 2));
        step(mk(0, 0, 32'h0,  32'h0, 0, 32'h0,   32'h0,        0, 1));
        step(mk(0, 0, 32'h0,  32'h0, 1, 32'h10,  32'h1,        0, 0));
        step(mk(0, 0, 32'h0,  32'h0, 1, 32'h14,  32'h2,        0, 0));
        step(mk(0, 0, 32'h0,  32'h0, 1, 32'h18,  32'h3,        0, 0));

        // Reset with a full buffer discards the pending writes.
        step(mk(0, 1, 32'h10, 32'h55, 1, 32'h100, 32'hDEADBEEF, 0, 0));
        step(mk(0, 1, 32'h14, 32'h66, 1, 32'h100, 32'hDEADBEEF, 0, 1));
        step(mk(1, 0, 32'h0,  32'h0,  1, 32'h100, 32'h0,        0, 2));
        step(mk(0, 0, 32'h0,  32'h0,  0, 32'h0,   32'h0,        0, 0));
        step(mk(0, 0, 32'h0,  32'h0,  1, 32'h10,  32'h1,        0, 0));
        step(mk(0, 0, 32'h0,  32'h0,  1, 32'h14,  32'h2,        0, 0));

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected completion before 100000");
        $fatal(1, "timeout");
    end

endmodule
